alu_nibble: RTL and testbench

//  4-bit, 8-operation ALU with a registered result and carry/borrow output.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_nibble_if.sv | 27 ++
 rtl/alu_addsub4.sv | 21 ++
 rtl/alu_nibble.sv | 136 +++++++++++++
 tb/tb_alu_nibble.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the nibble ALU: opcode enumeration and datapath width.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_NOT = 3'b001,
    OP_OR  = 3'b010,
    OP_XOR = 3'b011,
    OP_SHL = 3'b100,
    OP_ADD = 3'b101,
    OP_SUB = 3'b110,
    OP_NEG = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_nibble_if.sv
// Operation/result bundle of the nibble ALU; ALU_FLAGS_EN adds zero/negative/overflow.
interface alu_nibble_if;
  import alu_pkg::*;

  logic             in_valid;
  logic [ALU_W-1:0] acc_a;
  logic [ALU_W-1:0] acc_b;
  logic [2:0]       op;
  logic [ALU_W-1:0] result;
  logic             carry;
  logic             out_valid;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             overflow;

  modport master (output in_valid, acc_a, acc_b, op,
                  input  result, carry, out_valid, zero, negative, overflow);
  modport slave  (input  in_valid, acc_a, acc_b, op,
                  output result, carry, out_valid, zero, negative, overflow);
`else
  modport master (output in_valid, acc_a, acc_b, op,
                  input  result, carry, out_valid);
  modport slave  (input  in_valid, acc_a, acc_b, op,
                  output result, carry, out_valid);
`endif
endinterface

// File: rtl/alu_addsub4.sv
// Shared 4-bit adder: o_sum = i_x + (i_inv_y ? ~i_y : i_y) + i_cin, with carry-out.
module alu_addsub4
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_x,
  input  logic [ALU_W-1:0] i_y,
  input  logic             i_inv_y,
  input  logic             i_cin,
  output logic [ALU_W-1:0] o_sum,
  output logic             o_cout
);

  logic [ALU_W-1:0] w_y_eff;
  logic [ALU_W:0]   w_total;

  assign w_y_eff = i_inv_y ? ~i_y : i_y;
  assign w_total = {1'b0, i_x} + {1'b0, w_y_eff} + {{ALU_W{1'b0}}, i_cin};
  assign o_sum   = w_total[ALU_W-1:0];
  assign o_cout  = w_total[ALU_W];

endmodule

// File: rtl/alu_nibble.sv
// 4-bit, 8-op ALU with one output register stage; optional flags under ALU_FLAGS_EN.
module alu_nibble
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_nibble_if.slave  bus
);

  logic [ALU_W-1:0] w_x;
  logic [ALU_W-1:0] w_y;
  logic             w_inv_y;
  logic             w_cin;
  logic [ALU_W-1:0] w_sum;
  logic             w_cout;
  logic [ALU_W-1:0] w_result;
  logic             w_carry;
  logic             w_arith;

  logic [ALU_W-1:0] r_result;
  logic             r_carry;
  logic             r_out_valid;

  // NEG reuses the adder as 0 + ~A + 1
  alu_addsub4 u_addsub (
    .i_x     (w_x),
    .i_y     (w_y),
    .i_inv_y (w_inv_y),
    .i_cin   (w_cin),
    .o_sum   (w_sum),
    .o_cout  (w_cout)
  );

  always_comb begin
    w_x      = bus.acc_a;
    w_y      = bus.acc_b;
    w_inv_y  = 1'b0;
    w_cin    = 1'b0;
    w_result = {ALU_W{1'b0}};
    w_carry  = 1'b0;
    w_arith  = 1'b0;
    case (alu_op_e'(bus.op))
      OP_AND: w_result = bus.acc_a & bus.acc_b;
      OP_NOT: w_result = ~bus.acc_a;
      OP_OR:  w_result = bus.acc_a | bus.acc_b;
      OP_XOR: w_result = bus.acc_a ^ bus.acc_b;
      OP_SHL: begin
        w_result = {bus.acc_a[ALU_W-2:0], 1'b0};
        w_carry  = bus.acc_a[ALU_W-1];
      end
      OP_ADD: begin
        w_result = w_sum;
        w_carry  = w_cout;
        w_arith  = 1'b1;
      end
      OP_SUB: begin
        w_inv_y  = 1'b1;
        w_cin    = 1'b1;
        w_result = w_sum;
        w_carry  = ~w_cout;
        w_arith  = 1'b1;
      end
      OP_NEG: begin
        w_x      = {ALU_W{1'b0}};
        w_y      = bus.acc_a;
        w_inv_y  = 1'b1;
        w_cin    = 1'b1;
        w_result = w_sum;
        w_carry  = w_cout;
        w_arith  = 1'b1;
      end
      default: begin
        w_result = {ALU_W{1'b0}};
        w_carry  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= {ALU_W{1'b0}};
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_result;
        r_carry  <= w_carry;
      end else begin
        r_result <= r_result;
        r_carry  <= r_carry;
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.out_valid = r_out_valid;

`ifdef ALU_FLAGS_EN
  logic [ALU_W-1:0] w_y_eff;
  logic             w_overflow;
  logic             r_zero;
  logic             r_negative;
  logic             r_overflow;

  // Signed overflow: both adder operands share a sign the sum does not
  assign w_y_eff    = w_inv_y ? ~w_y : w_y;
  assign w_overflow = w_arith & (w_x[ALU_W-1] == w_y_eff[ALU_W-1])
                              & (w_sum[ALU_W-1] != w_x[ALU_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.in_valid) begin
      r_zero     <= (w_result == {ALU_W{1'b0}});
      r_negative <= w_result[ALU_W-1];
      r_overflow <= w_overflow;
    end else begin
      r_zero     <= r_zero;
      r_negative <= r_negative;
      r_overflow <= r_overflow;
    end
  end

  assign bus.zero     = r_zero;
  assign bus.negative = r_negative;
  assign bus.overflow = r_overflow;
`else
  logic w_arith_unused;
  assign w_arith_unused = w_arith;
`endif

endmodule

// File: tb/tb_alu_nibble.sv
// Self-checking bench for alu_nibble: directed cases, reset, hold, exhaustive sweep vs arithmetic model.
module tb_alu_nibble;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_nibble_if bus ();

  alu_nibble dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec = n_vec + 1;
    if (obs != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: returns carry*16 + result, from plain integer arithmetic
  function automatic int model(input int a, input int b, input int op);
    int r;
    int c;
    c = 0;
    case (op)
      0: r = a & b;
      1: r = 15 - a;
      2: r = a | b;
      3: r = a ^ b;
      4: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
      5: begin r = (a + b) % 16; c = (a + b >= 16) ? 1 : 0; end
      6: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      7: begin r = (16 - a) % 16; c = (a == 0) ? 1 : 0; end
      default: r = 0;
    endcase
    return c * 16 + r;
  endfunction

  function automatic int sgn(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int model_ovf(input int a, input int b, input int op);
    int s;
    case (op)
      5: s = sgn(a) + sgn(b);
      6: s = sgn(a) - sgn(b);
      7: s = -sgn(a);
      default: s = 0;
    endcase
    return (s > 7 || s < -8) ? 1 : 0;
  endfunction

  task automatic drive(input int a, input int b, input int op);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.acc_a    = 4'(a);
    bus.acc_b    = 4'(b);
    bus.op       = 3'(op);
  endtask

  task automatic op_check(input string tag, input int a, input int b, input int op);
    int e;
    drive(a, b, op);
    @(posedge clk);
    #1;
    e = model(a, b, op);
    chk({tag, ".result"}, int'(bus.result), e % 16);
    chk({tag, ".carry"}, int'(bus.carry), e / 16);
    chk({tag, ".valid"}, int'(bus.out_valid), 1);
`ifdef ALU_FLAGS_EN
    chk({tag, ".zero"}, int'(bus.zero), ((e % 16) == 0) ? 1 : 0);
    chk({tag, ".neg"}, int'(bus.negative), ((e % 16) >= 8) ? 1 : 0);
    chk({tag, ".ovf"}, int'(bus.overflow), model_ovf(a, b, op));
`endif
  endtask

  initial begin
    int last;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.acc_a = 4'b0000;
    bus.acc_b = 4'b0000;
    bus.op    = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.result", int'(bus.result), 0);
    chk("rst.carry", int'(bus.carry), 0);
    chk("rst.valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("add_ff_fe", 15, 14, 5);
    // Reset asserted mid-operation must clear outputs without a clock edge
    drive(12, 5, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.result", int'(bus.result), 0);
    chk("async_rst.carry", int'(bus.carry), 0);
    chk("async_rst.valid", int'(bus.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op_check("post_rst_add", 15, 14, 5);
    op_check("sub_3_5", 3, 5, 6);
    op_check("sub_5_3", 5, 3, 6);
    op_check("and", 12, 10, 0);
    op_check("or", 12, 10, 2);
    op_check("xor", 12, 10, 3);
    op_check("not", 12, 10, 1);
    op_check("shl_9", 9, 0, 4);
    op_check("neg_0", 0, 0, 7);
    op_check("neg_1", 1, 0, 7);
    op_check("add_7_1", 7, 1, 5);

    for (int op = 0; op < 8; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op_check("sweep", a, b, op);

    for (int k = 0; k < 200; k++)
      op_check("rand", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
               int'($urandom_range(7, 0)));

    op_check("hold_setup", 9, 3, 5);
    last = model(9, 3, 5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.acc_a = 4'(15);
    bus.op = 3'(1);
    @(posedge clk);
    #1;
    chk("idle.valid", int'(bus.out_valid), 0);
    chk("idle.result", int'(bus.result), last % 16);
    chk("idle.carry", int'(bus.carry), last / 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
